deser_align_ctrl: RTL and testbench



---
 rtl/deser_pkg.sv | 25 ++
 rtl/deser_align_ctrl.sv | 131 +++++++++++++
 tb/tb_deser_align_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/deser_pkg.sv
// Shared types and constants for the deserializer word-alignment controller.
package deser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_SLIP,
        ST_WAIT,
        ST_LOCKED,
        ST_FAIL
    } state_e;

    // Clock-lane training word for a 7:1 video link.
    localparam logic [6:0] TRAIN_PATTERN_7 = 7'b1100011;

    // Ceiling log2, never below 1 so it can size a vector directly.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/deser_align_ctrl.sv
// Bitslip controller: slips the deserializer until the training word appears,
// holds lock, and falls back to realignment after repeated mismatches.
module deser_align_ctrl
    import deser_pkg::*;
#(
    parameter int               WIDTH         = 7,
    parameter logic [WIDTH-1:0] TRAIN_PATTERN = WIDTH'(TRAIN_PATTERN_7),
    parameter int               SETTLE_CYC    = 8,
    parameter int               CALIB_GAP     = 4,
    parameter int               LOCK_COUNT    = 16,
    parameter int               LOSS_COUNT    = 4,
    parameter int               MAX_SLIPS     = 7
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             start_i,
    input  logic [WIDTH-1:0]                 word_i,
    output logic                             calib_o,
    output logic                             locked_o,
    output logic                             busy_o,
    output logic                             error_o,
    output logic [clog2(MAX_SLIPS+1)-1:0]    slip_cnt_o
);

    localparam int SW   = clog2(MAX_SLIPS + 1);
    localparam int MW   = clog2(LOCK_COUNT + 1);
    localparam int LW   = clog2(LOSS_COUNT + 1);
    localparam int TMAX = (SETTLE_CYC > CALIB_GAP) ? SETTLE_CYC : CALIB_GAP;
    localparam int TW   = clog2(TMAX + 1);

    state_e         state, state_nxt;
    logic [TW-1:0]  tmr;
    logic [MW-1:0]  match_cnt;
    logic [LW-1:0]  miss_cnt;
    logic [SW-1:0]  slip_cnt;

    logic hit, settle_done, gap_done, lock_hit, loss_hit, slip_max;

    assign hit         = (word_i == TRAIN_PATTERN);
    assign settle_done = (tmr == TW'(SETTLE_CYC - 1));
    assign gap_done    = (tmr == TW'(CALIB_GAP - 1));
    assign lock_hit    = hit && (match_cnt == MW'(LOCK_COUNT - 1));
    assign loss_hit    = !hit && (miss_cnt == LW'(LOSS_COUNT - 1));
    assign slip_max    = (slip_cnt == SW'(MAX_SLIPS));

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start_i) state_nxt = ST_SETTLE;
            ST_SETTLE: if (settle_done) state_nxt = ST_CHECK;
            ST_CHECK: begin
                if (lock_hit)      state_nxt = ST_LOCKED;
                else if (!hit)     state_nxt = slip_max ? ST_FAIL : ST_SLIP;
            end
            ST_SLIP:   state_nxt = ST_WAIT;
            ST_WAIT:   if (gap_done) state_nxt = ST_CHECK;
            ST_LOCKED: if (loss_hit) state_nxt = ST_SETTLE;
            ST_FAIL:   if (start_i) state_nxt = ST_SETTLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // One timer serves both SETTLE and WAIT; it is zeroed on every entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmr       <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            slip_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_FAIL: begin
                    if (start_i) begin
                        tmr      <= '0;
                        slip_cnt <= '0;
                    end
                end
                ST_SETTLE: begin
                    tmr       <= tmr + 1'b1;
                    match_cnt <= '0;
                end
                ST_CHECK: begin
                    miss_cnt <= '0;
                    if (hit) match_cnt <= match_cnt + 1'b1;
                end
                ST_SLIP: begin
                    tmr <= '0;
                    if (!slip_max) slip_cnt <= slip_cnt + 1'b1;
                end
                ST_WAIT: begin
                    tmr       <= tmr + 1'b1;
                    match_cnt <= '0;
                end
                ST_LOCKED: begin
                    if (hit) begin
                        miss_cnt <= '0;
                    end else if (loss_hit) begin
                        miss_cnt <= '0;
                        tmr      <= '0;
                    end else begin
                        miss_cnt <= miss_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are flopped from the next state so they line up with the state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            calib_o  <= 1'b0;
            locked_o <= 1'b0;
            busy_o   <= 1'b0;
            error_o  <= 1'b0;
        end else begin
            calib_o  <= (state_nxt == ST_SLIP);
            locked_o <= (state_nxt == ST_LOCKED);
            busy_o   <= (state_nxt inside {ST_SETTLE, ST_CHECK, ST_SLIP, ST_WAIT});
            error_o  <= (state_nxt == ST_FAIL);
        end
    end

    assign slip_cnt_o = slip_cnt;

endmodule

// File: tb/tb_deser_align_ctrl.sv
// Scoreboard bench: a rotating-word deserializer model feeds the controller and
// expected calib/lock/error events are queued and matched by a monitor.
module tb_deser_align_ctrl;

    localparam logic [6:0] PAT = 7'b1100011;
    localparam int EV_CALIB = 0;
    localparam int EV_LOCK  = 1;
    localparam int EV_ERR   = 2;

    typedef struct {
        int kind;
        int slip;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [6:0] word;
    logic       calib, locked, busy, error;
    logic [2:0] slip;

    always #5 clk = ~clk;

    deser_align_ctrl dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .word_i     (word),
        .calib_o    (calib),
        .locked_o   (locked),
        .busy_o     (busy),
        .error_o    (error),
        .slip_cnt_o (slip)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    ev_t  exp_q[$];
    bit   sb_en = 1'b0;
    int   mode = 0;          // 0: rotated pattern, 1: all zeros, 2: manual
    int   off_init = 0;
    int   pulses = 0;
    int   calib_seen = 0;
    logic [6:0] man_word = '0;

    function automatic logic [6:0] rotl(input logic [6:0] w, input int n);
        logic [6:0] r;
        r = w;
        for (int i = 0; i < n; i++) r = {r[5:0], r[6]};
        return r;
    endfunction

    // Deserializer model: every calib pulse shifts the word one more bit position.
    always @(negedge clk) begin
        if (rst) pulses = 0;
        else if (calib) pulses = pulses + 1;
    end

    assign word = (mode == 0) ? rotl(PAT, (off_init + pulses) % 7) :
                  (mode == 1) ? 7'h00 : man_word;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic expect_ev(input int kind, input int s);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_event", kind, -1);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            if (kind != EV_CALIB) chk("event_slip_cnt", s, e.slip);
        end
    endtask

    // Monitor
    logic prev_calib = 1'b0, prev_locked = 1'b0, prev_error = 1'b0;
    int   since_calib = 100;
    always @(posedge clk) begin
        #1;
        if (sb_en) begin
            if (calib && prev_calib) chk("calib_single_cycle", 1, 0);
            if (calib && !prev_calib) begin
                chk("calib_spacing", int'(since_calib >= 4), 1);
                expect_ev(EV_CALIB, int'(slip));
            end
            if (locked && !prev_locked) expect_ev(EV_LOCK, int'(slip));
            if (error && !prev_error) begin
                chk("busy_in_fail", int'(busy), 0);
                expect_ev(EV_ERR, int'(slip));
            end
        end
        if (calib && !prev_calib) calib_seen = calib_seen + 1;
        since_calib = rst ? 100 : (calib ? 0 : since_calib + 1);
        prev_calib  = calib;
        prev_locked = locked;
        prev_error  = error;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sb_en = 1'b0;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) step();
        exp_q.delete();
        rst = 1'b0;
        calib_seen = 0;
        step();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic push(input int kind, input int s);
        ev_t e;
        e.kind = kind;
        e.slip = s;
        exp_q.push_back(e);
    endtask

    task automatic push_align(input int k);
        for (int i = 0; i < k; i++) push(EV_CALIB, i + 1);
        push(EV_LOCK, k);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            step();
            n++;
        end
        chk(name, exp_q.size(), 0);
        step();
    endtask

    initial begin
        int k;

        // Reset state
        repeat (3) step();
        chk("rst_calib", int'(calib), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_slip", int'(slip), 0);

        // Already aligned, with a stray start pulse while checking
        do_reset();
        mode = 0; off_init = 0;
        push_align(0);
        sb_en = 1'b1;
        do_start();                          // edge 0 consumed
        repeat (11) step();                  // edge 11
        do_start();                          // edge 12, state CHECK
        repeat (11) step();                  // edge 23
        chk("aligned_not_locked_c23", int'(locked), 0);
        repeat (2) step();                   // edge 25
        chk("aligned_locked_c25", int'(locked), 1);
        chk("aligned_slip", int'(slip), 0);
        do_start();
        step();
        chk("start_in_locked_locked", int'(locked), 1);
        chk("start_in_locked_busy", int'(busy), 0);
        chk("aligned_no_calib", calib_seen, 0);
        wait_drain("aligned_drain");

        // Three rotations to go
        do_reset();
        mode = 0; off_init = 4;
        push_align(3);
        sb_en = 1'b1;
        do_start();
        wait_drain("rot3_drain");
        chk("rot3_slip", int'(slip), 3);
        chk("rot3_locked", int'(locked), 1);
        chk("rot3_calibs", calib_seen, 3);

        // Loss-of-lock filtering, then a real loss
        man_word = ~PAT;
        mode = 2;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) begin
                man_word = (i == 3) ? PAT : ~PAT;
                step();
                chk("lock_hold", int'(locked), 1);
            end
        end
        man_word = ~PAT;
        repeat (3) step();
        chk("loss_still_locked", int'(locked), 1);
        step();
        chk("loss_unlocked", int'(locked), 0);
        chk("loss_busy", int'(busy), 1);
        chk("loss_slip_kept", int'(slip), 3);
        push(EV_LOCK, 3);
        mode = 0;
        wait_drain("relock_drain");
        chk("relock_slip", int'(slip), 3);

        // Pattern never present
        do_reset();
        mode = 1;
        for (int i = 0; i < 7; i++) push(EV_CALIB, i + 1);
        push(EV_ERR, 7);
        sb_en = 1'b1;
        do_start();
        wait_drain("fail_drain");
        chk("fail_error", int'(error), 1);
        chk("fail_busy", int'(busy), 0);
        chk("fail_calibs", calib_seen, 7);
        sb_en = 1'b0;
        do_start();
        chk("restart_error", int'(error), 0);
        chk("restart_slip", int'(slip), 0);
        chk("restart_busy", int'(busy), 1);

        // Reset coinciding with a calib pulse, start held through reset
        do_reset();
        mode = 1;
        do_start();
        k = 0;
        while (!calib && k < 100) begin
            step();
            k++;
        end
        chk("calib_seen_before_rst", int'(calib), 1);
        rst = 1'b1;
        start = 1'b1;
        step();
        chk("rst_mid_calib", int'(calib), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_error", int'(error), 0);
        chk("rst_mid_locked", int'(locked), 0);
        chk("rst_mid_slip", int'(slip), 0);
        repeat (3) step();
        chk("rst_hold_busy", int'(busy), 0);
        rst = 1'b0;
        step();
        chk("post_rst_start_busy", int'(busy), 1);
        start = 1'b0;

        // Randomized starting offsets against the rotation model
        for (int r = 0; r < 6; r++) begin
            do_reset();
            mode = 0;
            off_init = $urandom_range(0, 6);
            k = (7 - off_init) % 7;
            push_align(k);
            sb_en = 1'b1;
            do_start();
            wait_drain("rand_drain");
            chk("rand_slip", int'(slip), k);
            chk("rand_calibs", calib_seen, k);
        end

        sb_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
